// File: rtl/cmd_defs_pkg.sv
// rtl/cmd_defs_pkg.sv - shared command opcode definitions for the command fetch and pointer blocks
// Contents: OPC_W (opcode field width, field sits in the top OPC_W bits of a word),
//           opcode_e (NUL/JMP/SJF/SJB), fetch_state_e, opc_is_legal().
package cmd_defs_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_NUL = 3'b000,
    OP_JMP = 3'b001,
    OP_SJF = 3'b010,
    OP_SJB = 3'b100
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_e;

  function automatic logic opc_is_legal(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_NUL, OP_JMP, OP_SJF, OP_SJB: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_decode.sv
// rtl/cmd_decode.sv - combinational instruction word decoder
// Ports: mem_rdata (instruction word in), opcode (legal opcode or NUL),
//        addr_to (zero-extended operand, 0 when illegal), illegal (opcode not recognised).
module cmd_decode
  import cmd_defs_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  output logic [OPC_W-1:0]     opcode,
  output logic [BUS_WIDTH-1:0] addr_to,
  output logic                 illegal
);

  logic [OPC_W-1:0] raw_opc;
  assign raw_opc = mem_rdata[BUS_WIDTH-1 -: OPC_W];

  always_comb begin
    illegal = !opc_is_legal(raw_opc);
    opcode  = OP_NUL;
    addr_to = '0;
    if (!illegal) begin
      opcode  = raw_opc;
      addr_to = {{OPC_W{1'b0}}, mem_rdata[BUS_WIDTH-OPC_W-1:0]};
    end
  end

endmodule

// File: rtl/cmd_fetch.sv
// rtl/cmd_fetch.sv - command fetch FSM: reads instruction words and issues decoded commands
// Ports: clk, nreset (async, active-low); enable, point_ready, addr_point from the pointer;
//        mem_req/mem_addr/mem_ack/mem_rdata read port; step/opcode/addr_to issue to the pointer;
//        err_illegal/err_timeout sticky flags cleared by err_clr.
module cmd_fetch
  import cmd_defs_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 enable,
  input  logic                 point_ready,
  input  logic [BUS_WIDTH-1:0] addr_point,
  output logic                 mem_req,
  output logic [BUS_WIDTH-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  output logic                 step,
  output logic [OPC_W-1:0]     opcode,
  output logic [BUS_WIDTH-1:0] addr_to,
  output logic                 err_illegal,
  output logic                 err_timeout,
  input  logic                 err_clr
);

  // wait_cnt counts FETCH cycles already spent without an ack, so the cycle in
  // which it equals TIMEOUT-1 is the last one; an ack in that cycle still wins.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  fetch_state_e         state;
  logic [7:0]           wait_cnt;
  logic [OPC_W-1:0]     dec_opcode;
  logic [BUS_WIDTH-1:0] dec_addr_to;
  logic                 dec_illegal;
  logic                 in_fetch;
  logic                 illegal_set;
  logic                 timeout_set;

  cmd_decode #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_decode (
    .mem_rdata(mem_rdata),
    .opcode   (dec_opcode),
    .addr_to  (dec_addr_to),
    .illegal  (dec_illegal)
  );

  // A dropped point_ready aborts the fetch, so neither error can be raised then.
  assign in_fetch    = (state == ST_FETCH) && point_ready;
  assign illegal_set = in_fetch && mem_ack && dec_illegal;
  assign timeout_set = in_fetch && !mem_ack && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      step        <= 1'b0;
      opcode      <= OP_NUL;
      addr_to     <= '0;
      wait_cnt    <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // Issue outputs are valid only during the single ISSUE cycle.
      step    <= 1'b0;
      opcode  <= OP_NUL;
      addr_to <= '0;

      if (!point_ready) begin
        state   <= ST_IDLE;
        mem_req <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (enable) begin
              state    <= ST_FETCH;
              mem_req  <= 1'b1;
              mem_addr <= addr_point;
              wait_cnt <= '0;
            end
          end
          // enable is deliberately ignored here: an outstanding read always completes.
          ST_FETCH: begin
            if (mem_ack) begin
              state   <= ST_ISSUE;
              mem_req <= 1'b0;
              step    <= 1'b1;
              opcode  <= dec_opcode;
              addr_to <= dec_addr_to;
            end else if (wait_cnt == WAIT_LIMIT) begin
              state   <= ST_ISSUE;
              mem_req <= 1'b0;
              step    <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          ST_ISSUE: begin
            if (enable) begin
              state    <= ST_FETCH;
              mem_req  <= 1'b1;
              mem_addr <= addr_point;
              wait_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        endcase
      end

      // Set has priority over clear.
      if (illegal_set)  err_illegal <= 1'b1;
      else if (err_clr) err_illegal <= 1'b0;

      if (timeout_set)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmd_fetch.sv
// tb/tb_cmd_fetch.sv - self-checking bench for cmd_fetch
module tb_cmd_fetch;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        nreset;
  logic        enable;
  logic        point_ready;
  logic [31:0] addr_point;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        step;
  logic [2:0]  opcode;
  logic [31:0] addr_to;
  logic        err_illegal;
  logic        err_timeout;
  logic        err_clr;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          delay;   // FETCH cycle index of the ack; >= TMO means never acked
    logic [2:0]  op;
    logic [31:0] to;
    bit          ill;
    bit          tmo;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   prev_step = 1'b0;
  vec_t vecs[10];

  cmd_fetch #(
    .BUS_WIDTH(32),
    .TIMEOUT  (TMO)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .enable     (enable),
    .point_ready(point_ready),
    .addr_point (addr_point),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .step       (step),
    .opcode     (opcode),
    .addr_to    (addr_to),
    .err_illegal(err_illegal),
    .err_timeout(err_timeout),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [31:0] to);
    exp_t e;
    e.op = op;
    e.to = to;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every step must match the oldest expected issue.
  always @(negedge clk) begin
    if (nreset && step) begin
      chk("step_one_cycle", {31'd0, prev_step}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_step", {31'd0, step}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("step_opcode", {29'd0, opcode}, {29'd0, mon_e.op});
        chk("step_addr_to", addr_to, mon_e.to);
      end
    end
    prev_step = nreset && step;
  end

  task automatic run_vec(input vec_t v);
    int reqs;
    int exp_reqs;
    bit seen;
    addr_point = v.addr;
    enable     = 1'b1;
    tick;
    chk("vec_req_start", {31'd0, mem_req}, 32'd1);
    chk("vec_mem_addr", mem_addr, v.addr);
    addr_point = v.addr + 32'h100;
    enable     = 1'b0;
    push_exp(v.op, v.to);
    reqs     = 1;
    seen     = 1'b0;
    exp_reqs = (v.delay < TMO) ? v.delay + 1 : TMO;
    for (int c = 0; c < 20 && !seen; c++) begin
      mem_ack   = (c == v.delay);
      mem_rdata = (c == v.delay) ? v.rdata : ~v.rdata;
      tick;
      if (step) begin
        seen = 1'b1;
        chk("issue_req_low", {31'd0, mem_req}, 32'd0);
      end else if (mem_req) begin
        reqs++;
        chk("vec_addr_stable", mem_addr, v.addr);
      end
    end
    mem_ack = 1'b0;
    chk("vec_step_seen", {31'd0, seen}, 32'd1);
    chk("vec_req_cycles", reqs, exp_reqs);
    tick;
    chk("idle_req", {31'd0, mem_req}, 32'd0);
    chk("idle_opcode", {29'd0, opcode}, 32'd0);
    chk("idle_addr_to", addr_to, 32'd0);
    tick;
    chk("err_illegal_held", {31'd0, err_illegal}, {31'd0, v.ill});
    chk("err_timeout_held", {31'd0, err_timeout}, {31'd0, v.tmo});
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("err_illegal_clr", {31'd0, err_illegal}, 32'd0);
    chk("err_timeout_clr", {31'd0, err_timeout}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h10, 32'h2000_0005, 1, 3'b001, 32'h5,         1'b0, 1'b0};
    vecs[1] = '{32'h20, 32'hE000_0003, 0, 3'b000, 32'h0,         1'b1, 1'b0};
    vecs[2] = '{32'h30, 32'h4000_0002, 2, 3'b010, 32'h2,         1'b0, 1'b0};
    vecs[3] = '{32'h40, 32'h8000_1234, 0, 3'b100, 32'h1234,      1'b0, 1'b0};
    vecs[4] = '{32'h50, 32'h0000_00AB, 0, 3'b000, 32'hAB,        1'b0, 1'b0};
    vecs[5] = '{32'h60, 32'h2000_0007, 9, 3'b000, 32'h0,         1'b0, 1'b1};
    vecs[6] = '{32'h70, 32'h3FFF_FFFF, 3, 3'b001, 32'h1FFF_FFFF, 1'b0, 1'b0};
    vecs[7] = '{32'h80, 32'hA000_0001, 3, 3'b000, 32'h0,         1'b1, 1'b0};
    vecs[8] = '{32'h90, 32'h6000_0000, 0, 3'b000, 32'h0,         1'b1, 1'b0};
    vecs[9] = '{32'hC0, 32'hFFFF_FFFF, 1, 3'b000, 32'h0,         1'b1, 1'b0};

    nreset      = 1'b0;
    enable      = 1'b0;
    point_ready = 1'b1;
    addr_point  = 32'h0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    err_clr     = 1'b0;
    tick;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_opcode", {29'd0, opcode}, 32'd0);
    chk("rst_addr_to", addr_to, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err_illegal", {31'd0, err_illegal}, 32'd0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    tick;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Back-to-back with ack held high; enable drops while in the fourth FETCH.
    addr_point = 32'h200;
    mem_rdata  = 32'h4000_0002;
    mem_ack    = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(3'b010, 32'd2);
    enable = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 7) enable = 1'b0;
      tick;
      chk("b2b_step", {31'd0, step}, {31'd0, (c % 2 == 1) && (c <= 7)});
      chk("b2b_req", {31'd0, mem_req}, {31'd0, (c % 2 == 0) && (c <= 6)});
    end
    for (int c = 0; c < 2; c++) begin
      tick;
      chk("ack_ignored_idle_req", {31'd0, mem_req}, 32'd0);
      chk("ack_ignored_idle_step", {31'd0, step}, 32'd0);
    end
    mem_ack = 1'b0;

    // point_ready falls mid-FETCH while an ack arrives: abort, no step.
    enable     = 1'b1;
    addr_point = 32'h280;
    tick;
    chk("pr_req_start", {31'd0, mem_req}, 32'd1);
    point_ready = 1'b0;
    mem_ack     = 1'b1;
    mem_rdata   = 32'h2000_0005;
    tick;
    chk("pr_abort_req", {31'd0, mem_req}, 32'd0);
    chk("pr_abort_step", {31'd0, step}, 32'd0);
    mem_ack = 1'b0;
    tick;
    chk("pr_stays_idle", {31'd0, mem_req}, 32'd0);
    enable      = 1'b0;
    point_ready = 1'b1;
    tick;

    // Clear and a new illegal error in the same cycle: set wins.
    enable = 1'b1;
    tick;
    mem_ack   = 1'b1;
    mem_rdata = 32'hE000_0000;
    err_clr   = 1'b1;
    push_exp(3'b000, 32'd0);
    tick;
    chk("set_wins_illegal", {31'd0, err_illegal}, 32'd1);
    mem_ack = 1'b0;
    err_clr = 1'b0;
    enable  = 1'b0;
    tick;
    chk("set_wins_held", {31'd0, err_illegal}, 32'd1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("set_wins_cleared", {31'd0, err_illegal}, 32'd0);

    // Reset asserted mid-FETCH, away from the clock edge.
    enable     = 1'b1;
    addr_point = 32'h300;
    tick;
    chk("rf_req_start", {31'd0, mem_req}, 32'd1);
    #2;
    nreset    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h2000_0009;
    #1;
    chk("rf_req_async", {31'd0, mem_req}, 32'd0);
    chk("rf_step", {31'd0, step}, 32'd0);
    chk("rf_mem_addr", mem_addr, 32'd0);
    chk("rf_opcode", {29'd0, opcode}, 32'd0);
    chk("rf_addr_to", addr_to, 32'd0);
    enable = 1'b0;
    tick;
    @(negedge clk);
    #1;
    nreset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("rf_no_step", {31'd0, step}, 32'd0);
      chk("rf_no_req", {31'd0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;
    run_vec(vecs[0]);

    tick;
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
